// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray/binary conversion and default geometry.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int PTR_W          = DEF_ADDR_WIDTH + 1;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

  // Callers zero-extend narrower pointers; zero upper bits convert to zero.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cnt_gray.sv
// Enable-gated binary/Gray counter pair; also exposes the next Gray value for flag look-ahead.
module cnt_gray #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] data_bin,
  output logic [DATA_WIDTH-1:0] data_gray,
  output logic [DATA_WIDTH-1:0] gray_next
);

  logic [DATA_WIDTH-1:0] bin_next;

  assign bin_next  = data_bin + DATA_WIDTH'(en);
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_bin  <= '0;
      data_gray <= '0;
    end else begin
      data_bin  <= bin_next;
      data_gray <= gray_next;
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded bus entering the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q1;

  // NOTE: non-blocking assignments make q take the old q1, giving two real stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= '0;
      q  <= '0;
    end else begin
      q1 <= d;
      q  <= q1;
    end
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointer, RAM strobe/address, registered full flag.
// Optional registered almost_full is enabled with `define FIFO_ALMOST_FULL_EN.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rptr_gray_i,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full
);

  localparam int PW         = ADDR_WIDTH + 1;
  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;

  logic [PW-1:0] rq2;
  logic [PW-1:0] wb;
  logic [PW-1:0] wg_next;
  logic          cnt_en;
  logic          full_next;

  sync_2ff #(.WIDTH(PW)) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rptr_gray_i),
    .q     (rq2)
  );

  assign cnt_en = wr_req & ~full;
  assign wr_en  = cnt_en;

  cnt_gray #(.DATA_WIDTH(PW)) u_wptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (cnt_en),
    .data_bin  (wb),
    .data_gray (wptr_gray),
    .gray_next (wg_next)
  );

  assign wr_addr = wb[ADDR_WIDTH-1:0];

  // Full when the next write pointer is exactly one lap ahead of the synced read pointer.
  assign full_next = (wg_next == {~rq2[ADDR_WIDTH:ADDR_WIDTH-1], rq2[ADDR_WIDTH-2:0]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else begin
      full <= full_next;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic [31:0]   rb_wide;
  logic [PW-1:0] rb_sync;
  logic [PW-1:0] wb_next;
  logic [PW-1:0] level;
  logic          af_next;
  logic          unused_rb_hi;

  assign rb_wide      = gray2bin(32'(rq2));
  assign rb_sync      = rb_wide[PW-1:0];
  assign unused_rb_hi = ^rb_wide[31:PW];
  assign wb_next      = wb + PW'(cnt_en);
  assign level        = wb_next - rb_sync;
  assign af_next      = (level >= PW'(FIFO_DEPTH - AF_THRESH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= af_next;
    end
  end
`else
  localparam int unused_af_thresh = AF_THRESH;
  logic unused_wb_msb;

  assign unused_wb_msb = wb[ADDR_WIDTH];
  assign almost_full   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed vector table, corner sequences, random traffic.
module tb_fifo_wr_ctrl;
  import fifo_pkg::*;

  localparam int PTR_MOD = 2 * DEPTH;
  localparam int AF_T    = 2;
`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_req = 1'b0;
  logic [PTR_W-1:0] rptr_gray_i = '0;
  logic             wr_en;
  logic [PTR_W-2:0] wr_addr;
  logic [PTR_W-1:0] wptr_gray;
  logic             full;
  logic             almost_full;

  fifo_wr_ctrl #(.ADDR_WIDTH(DEF_ADDR_WIDTH), .AF_THRESH(AF_T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .rptr_gray_i (rptr_gray_i),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: pointers as plain integers, occupancy by modular subtraction,
  // read pointer seen through a two-edge delay line.
  int m_wp, m_rq1, m_rq2, n_acc;
  bit m_full, m_af;

  task automatic model_reset();
    m_wp = 0; m_rq1 = 0; m_rq2 = 0; n_acc = 0;
    m_full = 1'b0; m_af = 1'b0;
  endtask

  function automatic logic [PTR_W-1:0] gray_of(input int b);
    logic [31:0] g;
    g = bin2gray(32'(b % PTR_MOD));
    return g[PTR_W-1:0];
  endfunction

  // Called at posedge+1: drive, check combinational outputs, clock, check registered outputs.
  task automatic step(input logic req, input int rd_bin, input string tag,
                      output logic pre_en, output logic [PTR_W-2:0] pre_addr);
    int acc, wp_next, lvl;
    wr_req      = req;
    rptr_gray_i = gray_of(rd_bin);
    #2;
    pre_en   = wr_en;
    pre_addr = wr_addr;
    check({tag, " wr_en"},   32'(wr_en),   32'(req && !m_full));
    check({tag, " wr_addr"}, 32'(wr_addr), 32'(m_wp % DEPTH));
    @(posedge clk);
    acc     = (req && !m_full) ? 1 : 0;
    wp_next = (m_wp + acc) % PTR_MOD;
    lvl     = (wp_next - m_rq2 + PTR_MOD) % PTR_MOD;
    m_full  = (lvl == DEPTH);
    m_af    = AF_ON && (lvl >= DEPTH - AF_T);
    m_rq2   = m_rq1;
    m_rq1   = rd_bin % PTR_MOD;
    m_wp    = wp_next;
    n_acc  += acc;
    #1;
    check({tag, " wptr_gray"},   32'(wptr_gray),   32'(gray_of(m_wp)));
    check({tag, " full"},        32'(full),        32'(m_full));
    check({tag, " almost_full"}, 32'(almost_full), 32'(m_af));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; wr_req = 1'b0; rptr_gray_i = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             req;
    int               rd_bin;
    logic             exp_en;
    logic [PTR_W-2:0] exp_addr;
    logic [PTR_W-1:0] exp_wg;
    logic             exp_full;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic             pe;
    logic [PTR_W-2:0] pa;
    bit               saw_wrap;
    int               rd_tot;
    int               gap;
    logic [PTR_W-2:0] prev_addr;

    // Fill, reject at full, release via read pointer 1, then write address 0 again.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 0, 1'b1, 3'(i), gray_of(i + 1), (i == 7)};
    vecs[8]  = '{1'b1, 0, 1'b0, 3'd0, 4'b1100, 1'b1};
    vecs[9]  = '{1'b0, 1, 1'b0, 3'd0, 4'b1100, 1'b1};
    vecs[10] = '{1'b0, 1, 1'b0, 3'd0, 4'b1100, 1'b1};
    vecs[11] = '{1'b0, 1, 1'b0, 3'd0, 4'b1100, 1'b0};
    vecs[12] = '{1'b1, 1, 1'b1, 3'd0, 4'b1101, 1'b1};

    // Reset held with the clock running.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst wptr_gray",   32'(wptr_gray),   32'(0));
    check("rst wr_addr",     32'(wr_addr),     32'(0));
    check("rst full",        32'(full),        32'(0));
    check("rst wr_en",       32'(wr_en),       32'(0));
    check("rst almost_full", 32'(almost_full), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].req, vecs[i].rd_bin, $sformatf("vec%0d", i), pe, pa);
      check($sformatf("vec%0d tbl wr_en", i),     32'(pe),        32'(vecs[i].exp_en));
      check($sformatf("vec%0d tbl wr_addr", i),   32'(pa),        32'(vecs[i].exp_addr));
      check($sformatf("vec%0d tbl wptr_gray", i), 32'(wptr_gray), 32'(vecs[i].exp_wg));
      check($sformatf("vec%0d tbl full", i),      32'(full),      32'(vecs[i].exp_full));
    end

    // almost_full rises on the 6th accept with the reader idle.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 0, "af_fill", pe, pa);
    check("af after 5", 32'(almost_full), 32'(0));
    step(1'b1, 0, "af_fill6", pe, pa);
    check("af after 6",   32'(almost_full), 32'(AF_ON));
    check("full after 6", 32'(full),        32'(0));

    // Full lap with the reader tracking the writer.
    do_reset();
    saw_wrap  = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, m_wp, "lap", pe, pa);
      if (i > 0 && prev_addr == 3'd7 && pa == 3'd0) saw_wrap = 1'b1;
      prev_addr = pa;
      check("lap full low", 32'(full), 32'(0));
    end
    check("lap wptr_gray home", 32'(wptr_gray), 32'(0));
    check("lap addr wrapped",   32'(saw_wrap),  32'(1));

    // Asynchronous reset between edges in the middle of a burst.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 0, "burst", pe, pa);
    #3;
    rst_n  = 1'b0;
    wr_req = 1'b0;
    #1;
    check("midrst wptr_gray",   32'(wptr_gray),   32'(0));
    check("midrst wr_addr",     32'(wr_addr),     32'(0));
    check("midrst full",        32'(full),        32'(0));
    check("midrst almost_full", 32'(almost_full), 32'(0));
    check("midrst wr_en",       32'(wr_en),       32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(1'b1, 0, "resume", pe, pa);
    check("resume addr0", 32'(pa), 32'(0));

    // Random producer against a slower reader that never passes the writer.
    do_reset();
    rd_tot = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        gap = n_acc - rd_tot;
        if (gap > 0) rd_tot += int'($urandom_range(0, gap));
      end
      step($urandom_range(0, 3) != 0, rd_tot, "rand", pe, pa);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
